// File: rtl/vga_pkg.sv
// vga_pkg -- shared 640x480@60 timing constants and the timing record used
// by the sync generator.
//   coord_t       10-bit horizontal/vertical coordinate
//   vga_timing_t  totals, sync widths and visible-window bounds of one mode
//   VGA_640X480   the standard mode built from the constants below
//   in_span()     inclusive range test used by the window decode
package vga_pkg;

  localparam int H_TOTAL     = 800;
  localparam int H_SYNC      = 96;
  localparam int H_VIS_START = 144;
  localparam int H_VIS_END   = 783;
  localparam int V_TOTAL     = 521;
  localparam int V_SYNC      = 2;
  localparam int V_VIS_START = 31;
  localparam int V_VIS_END   = 510;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    coord_t h_total;
    coord_t h_sync;
    coord_t h_vis_start;
    coord_t h_vis_end;
    coord_t v_total;
    coord_t v_sync;
    coord_t v_vis_start;
    coord_t v_vis_end;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480 = '{
    h_total:     coord_t'(H_TOTAL),
    h_sync:      coord_t'(H_SYNC),
    h_vis_start: coord_t'(H_VIS_START),
    h_vis_end:   coord_t'(H_VIS_END),
    v_total:     coord_t'(V_TOTAL),
    v_sync:      coord_t'(V_SYNC),
    v_vis_start: coord_t'(V_VIS_START),
    v_vis_end:   coord_t'(V_VIS_END)
  };

  function automatic logic in_span(coord_t x, coord_t lo, coord_t hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_if.sv
// vga_sync_if -- timing stream produced by vga_sync.
//   pix_en      pixel-advance strobe
//   h_count     horizontal position
//   v_count     vertical line
//   hsync/vsync active-low sync pulses
//   video_on    visible-window flag
//   frame_start one-clk pulse on wrap to (0,0)
//   anim_tick   one-clk pulse every FRAMES_PER_TICK frames
//   anim_level  square wave toggling on each anim_tick
// Handshake: there is no valid/ready pair. The stream is free-running and
// cannot be stalled; pix_en is the only qualifier, and every other signal is
// stable for the whole pixel it describes.
interface vga_sync_if;
  import vga_pkg::*;

  logic   pix_en;
  coord_t h_count;
  coord_t v_count;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   frame_start;
  logic   anim_tick;
  logic   anim_level;

  modport master (
    output pix_en, h_count, v_count, hsync, vsync, video_on,
           frame_start, anim_tick, anim_level
  );

  modport slave (
    input pix_en, h_count, v_count, hsync, vsync, video_on,
          frame_start, anim_tick, anim_level
  );
endinterface

// File: rtl/pix_tick_gen.sv
// pix_tick_gen -- divides clk down to a one-clk pixel strobe.
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   pix_en  high in the clk where the divider sits at CLK_DIV-1
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div_q;
  logic       at_last;

  assign at_last = (div_q == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (at_last) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 4'd1;
    end
  end

  // With CLK_DIV=1 the divider is always at its last value, so the strobe
  // is gated by reset to keep it low while rst_n is asserted.
  assign pix_en = rst_n & at_last;

endmodule

// File: rtl/vga_sync.sv
// vga_sync -- VGA timing generator with frame-rate animation tick.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   vga    vga_sync_if.master: pix_en, h_count, v_count, hsync, vsync,
//          video_on, frame_start, anim_tick, anim_level
// TIMING defaults to 640x480; it only exists so a reduced mode can be built.
module vga_sync
  import vga_pkg::*;
#(
  parameter int          CLK_DIV         = 2,
  parameter int          FRAMES_PER_TICK = 60,
  parameter vga_timing_t TIMING          = VGA_640X480
) (
  input  logic        clk,
  input  logic        rst_n,
  vga_sync_if.master  vga
);

  localparam coord_t     H_LAST     = TIMING.h_total - 10'd1;
  localparam coord_t     V_LAST     = TIMING.v_total - 10'd1;
  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_TICK - 1);

  logic       pix_en;
  coord_t     h_q, v_q;
  coord_t     h_next, v_next;
  logic       h_wrap, v_wrap;
  logic       hsync_q, vsync_q, video_on_q;
  logic       frame_start_q, anim_tick_q, anim_level_q;
  logic [7:0] frame_q;

  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en)
  );

  // Next-count values; the decoded outputs are registered from these so
  // they line up with h_q/v_q in the same cycle.
  always_comb begin
    h_wrap = pix_en && (h_q == H_LAST);
    v_wrap = h_wrap && (v_q == V_LAST);
    h_next = h_q;
    v_next = v_q;
    if (pix_en) begin
      h_next = h_wrap ? '0 : h_q + 10'd1;
    end
    if (h_wrap) begin
      v_next = v_wrap ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      anim_tick_q   <= 1'b0;
      anim_level_q  <= 1'b0;
      frame_q       <= '0;
    end else begin
      h_q           <= h_next;
      v_q           <= v_next;
      hsync_q       <= (h_next >= TIMING.h_sync);
      vsync_q       <= (v_next >= TIMING.v_sync);
      video_on_q    <= in_span(h_next, TIMING.h_vis_start, TIMING.h_vis_end) &&
                       in_span(v_next, TIMING.v_vis_start, TIMING.v_vis_end);
      // The frame pulse and anim tick are registered together so a tick
      // always coincides with the frame_start that caused it.
      frame_start_q <= v_wrap;
      anim_tick_q   <= v_wrap && (frame_q == FRAME_LAST);
      if (v_wrap) begin
        if (frame_q == FRAME_LAST) begin
          frame_q      <= '0;
          anim_level_q <= ~anim_level_q;
        end else begin
          frame_q <= frame_q + 8'd1;
        end
      end
    end
  end

  assign vga.pix_en      = pix_en;
  assign vga.h_count     = h_q;
  assign vga.v_count     = v_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.frame_start = frame_start_q;
  assign vga.anim_tick   = anim_tick_q;
  assign vga.anim_level  = anim_level_q;

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync -- four vga_sync instances (two at full 640x480 timing, two at
// a reduced mode so whole frames fit a short run) checked cycle by cycle
// against a pixel-count reference model.
module tb_vga_sync;
  import vga_pkg::*;

  typedef struct packed {
    logic       pix_en;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;
    logic       anim_tick;
    logic       anim_level;
  } obs_t;

  localparam vga_timing_t REAL = '{
    h_total: 10'd800, h_sync: 10'd96, h_vis_start: 10'd144, h_vis_end: 10'd783,
    v_total: 10'd521, v_sync: 10'd2,  v_vis_start: 10'd31,  v_vis_end: 10'd510
  };
  localparam vga_timing_t SMALL = '{
    h_total: 10'd20, h_sync: 10'd3, h_vis_start: 10'd5, h_vis_end: 10'd16,
    v_total: 10'd12, v_sync: 10'd2, v_vis_start: 10'd3, v_vis_end: 10'd9
  };

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_a, rst_b, rst_c, rst_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  vga_sync_if if_a();
  vga_sync_if if_b();
  vga_sync_if if_c();
  vga_sync_if if_d();

  vga_sync #(.CLK_DIV(1), .FRAMES_PER_TICK(2)) u_dut_a (
    .clk(clk), .rst_n(rst_a), .vga(if_a));
  vga_sync #(.CLK_DIV(2), .FRAMES_PER_TICK(60)) u_dut_b (
    .clk(clk), .rst_n(rst_b), .vga(if_b));
  vga_sync #(.CLK_DIV(2), .FRAMES_PER_TICK(3), .TIMING(SMALL)) u_dut_c (
    .clk(clk), .rst_n(rst_c), .vga(if_c));
  vga_sync #(.CLK_DIV(3), .FRAMES_PER_TICK(1), .TIMING(SMALL)) u_dut_d (
    .clk(clk), .rst_n(rst_d), .vga(if_d));

  obs_t obs_a, obs_b, obs_c, obs_d;
  assign obs_a = {if_a.pix_en, if_a.h_count, if_a.v_count, if_a.hsync, if_a.vsync,
                  if_a.video_on, if_a.frame_start, if_a.anim_tick, if_a.anim_level};
  assign obs_b = {if_b.pix_en, if_b.h_count, if_b.v_count, if_b.hsync, if_b.vsync,
                  if_b.video_on, if_b.frame_start, if_b.anim_tick, if_b.anim_level};
  assign obs_c = {if_c.pix_en, if_c.h_count, if_c.v_count, if_c.hsync, if_c.vsync,
                  if_c.video_on, if_c.frame_start, if_c.anim_tick, if_c.anim_level};
  assign obs_d = {if_d.pix_en, if_d.h_count, if_d.v_count, if_d.hsync, if_d.vsync,
                  if_d.video_on, if_d.frame_start, if_d.anim_tick, if_d.anim_level};

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fails  = 0;
  logic [0:0] exp_q[$];

  // Reference model: c is the number of rising edges since reset release.
  // Pixels advance on every CLK_DIV-th edge, so the pixel index is c/n and
  // everything else follows from that index by plain arithmetic.
  function automatic obs_t model(int c, int n, int fpt, vga_timing_t t);
    obs_t o;
    int ht = int'(t.h_total);
    int vt = int'(t.v_total);
    int fr = ht * vt;
    int p  = c / n;
    int h  = p % ht;
    int v  = (p / ht) % vt;
    int f  = p / fr;
    logic stepped = (c > 0) && (c % n == 0);
    o.pix_en      = ((c % n) == (n - 1));
    o.h_count     = 10'(h);
    o.v_count     = 10'(v);
    o.hsync       = (h >= int'(t.h_sync));
    o.vsync       = (v >= int'(t.v_sync));
    o.video_on    = (h >= int'(t.h_vis_start)) && (h <= int'(t.h_vis_end)) &&
                    (v >= int'(t.v_vis_start)) && (v <= int'(t.v_vis_end));
    o.frame_start = stepped && (p % fr == 0);
    o.anim_tick   = o.frame_start && (f % fpt == 0);
    o.anim_level  = ((f / fpt) % 2) == 1;
    return o;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int hold;
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    hold = $urandom_range(2, 5);
    repeat (hold) @(negedge clk);
    #2;
    n_checks++;
    if (obs_a !== '0) begin n_fails++; $display("FAIL reset_a actual=%h required=0", obs_a); end
    n_checks++;
    if (obs_b !== '0) begin n_fails++; $display("FAIL reset_b actual=%h required=0", obs_b); end
    n_checks++;
    if (obs_c !== '0) begin n_fails++; $display("FAIL reset_c actual=%h required=0", obs_c); end
    n_checks++;
    if (obs_d !== '0) begin n_fails++; $display("FAIL reset_d actual=%h required=0", obs_d); end
  endtask

  // CLK_DIV=2 at full timing: first line, wrap at 1600 clocks onto line 1.
  task automatic test_clk_div2();
    obs_t e;
    @(negedge clk);
    rst_b = 1'b1;
    #1;
    e = model(0, 2, 60, REAL);
    n_checks++;
    if (obs_b !== e) begin n_fails++; $display("FAIL div2_stream c=0 actual=%h required=%h", obs_b, e); end
    for (int c = 1; c <= 1700; c++) begin
      @(negedge clk);
      e = model(c, 2, 60, REAL);
      n_checks++;
      if (obs_b !== e) begin
        n_fails++; $display("FAIL div2_stream c=%0d actual=%h required=%h", c, obs_b, e);
      end
      if (c == 1598) begin
        n_checks++;
        if (obs_b.h_count !== 10'd799) begin
          n_fails++; $display("FAIL div2_h799 actual=%0d required=799", obs_b.h_count);
        end
      end
      if (c == 1600) begin
        n_checks++;
        if (obs_b.h_count !== 10'd0 || obs_b.v_count !== 10'd1) begin
          n_fails++;
          $display("FAIL div2_wrap actual=(%0d,%0d) required=(0,1)", obs_b.h_count, obs_b.v_count);
        end
      end
    end
  endtask

  // CLK_DIV=1 at full timing: run into line 32, checking the visible-window
  // edges on line 31, then reset asynchronously at h=400.
  task automatic test_clk_div1_window();
    obs_t e;
    int   n_low = 0;
    int   d;
    int   hold;
    @(negedge clk);
    rst_a = 1'b1;
    #1;
    e = model(0, 1, 2, REAL);
    n_checks++;
    if (obs_a !== e) begin n_fails++; $display("FAIL div1_stream c=0 actual=%h required=%h", obs_a, e); end
    for (int c = 1; c <= 26000; c++) begin
      @(negedge clk);
      e = model(c, 1, 2, REAL);
      n_checks++;
      if (obs_a !== e) begin
        n_fails++; $display("FAIL div1_stream c=%0d actual=%h required=%h", c, obs_a, e);
      end
      if (!obs_a.pix_en) n_low++;
      if (c == 31 * 800 + 143) begin
        n_checks++;
        if (obs_a.video_on !== 1'b0 || obs_a.h_count !== 10'd143) begin
          n_fails++; $display("FAIL vis_h143 actual=%b/%0d required=0/143", obs_a.video_on, obs_a.h_count);
        end
      end
      if (c == 31 * 800 + 144) begin
        n_checks++;
        if (obs_a.video_on !== 1'b1 || obs_a.h_count !== 10'd144) begin
          n_fails++; $display("FAIL vis_h144 actual=%b/%0d required=1/144", obs_a.video_on, obs_a.h_count);
        end
      end
      if (c == 31 * 800 + 783) begin
        n_checks++;
        if (obs_a.video_on !== 1'b1) begin
          n_fails++; $display("FAIL vis_h783 actual=%b required=1", obs_a.video_on);
        end
      end
      if (c == 31 * 800 + 784) begin
        n_checks++;
        if (obs_a.video_on !== 1'b0 || obs_a.h_count !== 10'd784) begin
          n_fails++; $display("FAIL vis_h784 actual=%b/%0d required=0/784", obs_a.video_on, obs_a.h_count);
        end
      end
    end
    n_checks++;
    if (n_low != 0) begin n_fails++; $display("FAIL div1_pix_en_low actual=%0d required=0", n_low); end

    // Now at (400,32), inside the visible window.
    @(posedge clk);
    d = $urandom_range(1, 3);
    #(d);
    rst_a = 1'b0;
    #1;
    n_checks++;
    if (obs_a !== '0) begin n_fails++; $display("FAIL async_reset_a actual=%h required=0", obs_a); end
    hold = $urandom_range(1, 4);
    repeat (hold) @(negedge clk);
    rst_a = 1'b1;
    #1;
    e = model(0, 1, 2, REAL);
    n_checks++;
    if (obs_a !== e) begin n_fails++; $display("FAIL restart_a c=0 actual=%h required=%h", obs_a, e); end
    for (int c = 1; c <= 900; c++) begin
      @(negedge clk);
      e = model(c, 1, 2, REAL);
      n_checks++;
      if (obs_a !== e) begin
        n_fails++; $display("FAIL restart_a c=%0d actual=%h required=%h", c, obs_a, e);
      end
    end
  endtask

  // Reduced mode, CLK_DIV=2, FRAMES_PER_TICK=3: random mid-frame reset, then
  // seven whole frames with per-frame tallies and the anim_level sequence.
  task automatic test_full_frame();
    obs_t e;
    int   r, d, hold;
    int   hs_low = 0, vs_low = 0, vis = 0, n_fs = 0, n_tick = 0;
    int   frame_clks = 20 * 12 * 2;
    int   run = 7 * frame_clks + 10;
    @(negedge clk);
    rst_c = 1'b1;
    r = $urandom_range(50, 400);
    for (int c = 1; c <= r; c++) begin
      @(negedge clk);
      e = model(c, 2, 3, SMALL);
      n_checks++;
      if (obs_c !== e) begin
        n_fails++; $display("FAIL pre_reset_c c=%0d actual=%h required=%h", c, obs_c, e);
      end
    end
    @(posedge clk);
    d = $urandom_range(1, 3);
    #(d);
    rst_c = 1'b0;
    #1;
    n_checks++;
    if (obs_c !== '0) begin n_fails++; $display("FAIL async_reset_c actual=%h required=0", obs_c); end
    hold = $urandom_range(1, 4);
    repeat (hold) @(negedge clk);

    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    rst_c = 1'b1;
    #1;
    for (int c = 0; c <= run; c++) begin
      if (c > 0) @(negedge clk);
      e = model(c, 2, 3, SMALL);
      n_checks++;
      if (obs_c !== e) begin
        n_fails++; $display("FAIL frame_c c=%0d actual=%h required=%h", c, obs_c, e);
      end
      if (c < frame_clks && obs_c.pix_en) begin
        if (!obs_c.hsync)   hs_low++;
        if (!obs_c.vsync)   vs_low++;
        if (obs_c.video_on) vis++;
      end
      if (obs_c.frame_start) n_fs++;
      if (obs_c.anim_tick) begin
        n_tick++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++; $display("FAIL anim_level_extra_tick c=%0d actual=tick required=none", c);
        end else begin
          if (obs_c.anim_level !== exp_q[0]) begin
            n_fails++;
            $display("FAIL anim_level c=%0d actual=%b required=%b", c, obs_c.anim_level, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
    end
    n_checks++;
    if (hs_low != 3 * 12) begin n_fails++; $display("FAIL hsync_low_pixels actual=%0d required=36", hs_low); end
    n_checks++;
    if (vs_low != 2 * 20) begin n_fails++; $display("FAIL vsync_low_pixels actual=%0d required=40", vs_low); end
    n_checks++;
    if (vis != 12 * 7) begin n_fails++; $display("FAIL visible_pixels actual=%0d required=84", vis); end
    n_checks++;
    if (n_fs != 7) begin n_fails++; $display("FAIL frame_start_count actual=%0d required=7", n_fs); end
    n_checks++;
    if (n_tick != 2) begin n_fails++; $display("FAIL anim_tick_count actual=%0d required=2", n_tick); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL anim_level_missing actual=%0d required=0", exp_q.size()); end
  endtask

  // Reduced mode, CLK_DIV=3, FRAMES_PER_TICK=1: every frame_start ticks.
  task automatic test_fpt1();
    obs_t e;
    int   n_fs = 0, n_tick = 0, n_skew = 0;
    int   run = 3 * 20 * 12 * 3 + 20;
    @(negedge clk);
    rst_d = 1'b1;
    #1;
    for (int c = 0; c <= run; c++) begin
      if (c > 0) @(negedge clk);
      e = model(c, 3, 1, SMALL);
      n_checks++;
      if (obs_d !== e) begin
        n_fails++; $display("FAIL fpt1_d c=%0d actual=%h required=%h", c, obs_d, e);
      end
      if (obs_d.frame_start) n_fs++;
      if (obs_d.anim_tick)   n_tick++;
      if (obs_d.frame_start !== obs_d.anim_tick) n_skew++;
    end
    n_checks++;
    if (n_fs != 3 || n_tick != 3) begin
      n_fails++; $display("FAIL fpt1_counts actual=%0d/%0d required=3/3", n_fs, n_tick);
    end
    n_checks++;
    if (n_skew != 0) begin n_fails++; $display("FAIL fpt1_coincide actual=%0d required=0", n_skew); end
    n_checks++;
    if (obs_d.anim_level !== 1'b1) begin
      n_fails++; $display("FAIL fpt1_level actual=%b required=1", obs_d.anim_level);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    test_reset();
    test_clk_div2();
    test_clk_div1_window();
    test_full_frame();
    test_fpt1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
